// File: rtl/rr_reg_write_arbiter.sv
// rr_reg_write_arbiter: round-robin arbiter sharing one DEPTH x WIDTH register bank
// among N_REQ write requesters, with locked bursts of up to MAX_BURST writes per grant.
module rr_reg_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ-1:0]        req_lock_i,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*WIDTH-1:0]  req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    grant_valid_o,
    output logic [2:0]              grant_id_o,
    output logic                    addr_err_o,
    output logic [DEPTH*WIDTH-1:0]  reg_q_o
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, OWN} state_e;
    state_e                   state_q;
    logic [2:0]               rr_ptr_q;
    logic [2:0]               grant_id_q;
    logic [CNT_W-1:0]         burst_cnt_q;
    logic                     addr_err_q;
    logic [DEPTH*WIDTH-1:0]   regs_q;
    logic [2:0]               winner_d;
    logic [2:0]               next_ptr;
    logic [3:0]               scan;
    logic [7:0]               valid_x;
    logic [7:0]               lock_x;
    logic [8*ADDR_W-1:0]      addr_x;
    logic [8*WIDTH-1:0]       data_x;
    logic                     own_valid;
    logic                     own_lock;
    logic                     own_bad;
    logic                     last_beat;
    logic [ADDR_W-1:0]        own_addr;
    logic [WIDTH-1:0]         own_data;
    // Pad request buses to 8 lanes so the 3-bit owner index selects without range issues
    assign valid_x   = 8'(req_valid_i);
    assign lock_x    = 8'(req_lock_i);
    assign addr_x    = (8*ADDR_W)'(req_addr_i);
    assign data_x    = (8*WIDTH)'(req_data_i);
    assign own_valid = valid_x[grant_id_q];
    assign own_lock  = lock_x[grant_id_q];
    assign own_addr  = addr_x[grant_id_q*ADDR_W +: ADDR_W];
    assign own_data  = data_x[grant_id_q*WIDTH +: WIDTH];
    assign own_bad   = 32'(own_addr) >= DEPTH;
    assign last_beat = !own_lock || (32'(burst_cnt_q) + 1 == MAX_BURST);
    assign next_ptr  = (grant_id_q == 3'(N_REQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
    // Scan from farthest offset down so the lowest offset from rr_ptr wins
    always_comb begin
        winner_d = rr_ptr_q;
        scan     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan     = {1'b0, rr_ptr_q} + 4'(k);
            scan     = (scan >= 4'(N_REQ)) ? scan - 4'(N_REQ) : scan;
            winner_d = valid_x[scan[2:0]] ? scan[2:0] : winner_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            addr_err_q  <= 1'b0;
            regs_q      <= '0;
        end else if (state_q == IDLE) begin
            addr_err_q <= 1'b0;
            if (|req_valid_i) begin
                state_q     <= OWN;
                grant_id_q  <= winner_d;
                burst_cnt_q <= '0;
            end
        end else begin
            addr_err_q <= own_valid && own_bad;
            if (own_valid) begin
                burst_cnt_q <= burst_cnt_q + 1'b1;
                for (int i = 0; i < DEPTH; i++)
                    if (own_addr == ADDR_W'(i))
                        regs_q[i*WIDTH +: WIDTH] <= own_data;
            end
            if (!own_valid || last_beat) begin
                state_q  <= IDLE;
                rr_ptr_q <= next_ptr;
            end
        end
    end
    assign req_ready_o   = (state_q == OWN) ? N_REQ'(1) << grant_id_q : '0;
    assign grant_valid_o = state_q == OWN;
    assign grant_id_o    = grant_id_q;
    assign addr_err_o    = addr_err_q;
    assign reg_q_o       = regs_q;
endmodule
